// File: rtl/zircon_tlc5620_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zircon_tlc5620_pkg
//  Description : Shared types and constants for the TLC5620 DAC write core.
//  Revision    : 1.0 - initial release
// ============================================================================
package zircon_tlc5620_pkg;

  // Serial engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // A1 A0 RNG D7..D0
  localparam int FRAME_BITS = 11;

  // Avalon register map
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // STATUS register bit positions
  localparam int BUSY = 0;
  localparam int PEND = 1;
  localparam int OVR  = 2;

endpackage
`default_nettype wire

// File: rtl/zircon_avalon_tlc5620_logic.sv
`default_nettype none
// ============================================================================
//  Module      : zircon_avalon_tlc5620_logic
//  Description : Serial engine - shifts one 11-bit frame MSB first, then
//                pulses LOAD low for one half-period followed by a gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module zircon_avalon_tlc5620_logic
  import zircon_tlc5620_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  busy,
  output logic                  da_clk,
  output logic                  da_data,
  output logic                  da_load
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_TOP  = 4'(FRAME_BITS - 1);

  state_t                state, state_n;
  logic [DIV_W-1:0]      div, div_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  // phase 0 = high half of a bit, phase 1 = low half (DAC samples on the fall)
  logic                  phase, phase_n;
  logic                  wrap;

  assign wrap = (div == DIV_LAST);
  assign busy = (state != IDLE);

  // State, divider and shifter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      phase   <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      phase   <= phase_n;
    end
  end

  // Next-state logic; each divider wrap ends one half-period
  always_comb begin
    state_n   = state;
    div_n     = wrap ? '0 : div + 1'b1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    phase_n   = phase;
    case (state)
      IDLE: begin
        div_n = '0;
        if (start) begin
          shreg_n   = word;
          bit_cnt_n = BIT_TOP;
          phase_n   = 1'b0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (wrap) begin
          if (!phase) begin
            phase_n = 1'b1;
          end else if (bit_cnt == 4'd0) begin
            state_n = LOAD;
          end else begin
            bit_cnt_n = bit_cnt - 4'd1;
            phase_n   = 1'b0;
            shreg_n   = {shreg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      LOAD: begin
        if (wrap) state_n = GAP;
      end
      GAP: begin
        if (wrap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pins are registered from next-state values so they are glitch free and
  // line up exactly with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      da_clk  <= 1'b0;
      da_data <= 1'b0;
      da_load <= 1'b1;
    end else begin
      da_clk  <= (state_n == SHIFT) && !phase_n;
      da_data <= (state_n == SHIFT) && shreg_n[FRAME_BITS-1];
      da_load <= (state_n != LOAD);
    end
  end

endmodule
`default_nettype wire

// File: rtl/zircon_avalon_tlc5620.sv
`default_nettype none
// ============================================================================
//  Module      : zircon_avalon_tlc5620
//  Description : Avalon-MM write slave for a TLC5620-class 4-channel DAC.
//                Holds one pending word ahead of the serial engine and flags
//                overrun when an unsent word is overwritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module zircon_avalon_tlc5620
  import zircon_tlc5620_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic        avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        coe_da_clk,
  output logic        coe_da_data,
  output logic        coe_da_load,
  output logic        coe_da_ldac
);

  logic [FRAME_BITS-1:0] last_word;
  logic [FRAME_BITS-1:0] pending_word;
  logic                  pending_valid;
  logic                  overrun;
  logic                  busy;
  logic                  pop;
  logic                  wr_data;
  logic                  rd_status;
  logic                  ovr_set;
  logic [2:0]            status;
  logic                  unused_bits;

  assign unused_bits = ^avs_writedata[31:FRAME_BITS];

  // The engine takes the pending word the first idle cycle it sees one
  assign pop       = pending_valid && !busy;
  assign wr_data   = avs_write && (avs_address == ADDR_DATA);
  assign rd_status = avs_read  && (avs_address == ADDR_STATUS);
  assign ovr_set   = wr_data && pending_valid && !pop;

  assign coe_da_ldac = 1'b0;

  // Status vector assembly
  always_comb begin
    status       = '0;
    status[BUSY] = busy;
    status[PEND] = pending_valid;
    status[OVR]  = overrun;
  end

  // Pending slot, last written word and overrun flag (set beats clear)
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      last_word     <= '0;
      pending_word  <= '0;
      pending_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (wr_data) begin
        last_word    <= avs_writedata[FRAME_BITS-1:0];
        pending_word <= avs_writedata[FRAME_BITS-1:0];
      end
      if (wr_data)  pending_valid <= 1'b1;
      else if (pop) pending_valid <= 1'b0;
      if (ovr_set)        overrun <= 1'b1;
      else if (rd_status) overrun <= 1'b0;
    end
  end

  // Registered read data, one cycle latency
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      if (avs_address == ADDR_STATUS) avs_readdata <= {29'b0, status};
      else                            avs_readdata <= {21'b0, last_word};
    end
  end

  zircon_avalon_tlc5620_logic #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (csi_clk),
    .rst     (rsi_reset),
    .start   (pop),
    .word    (pending_word),
    .busy    (busy),
    .da_clk  (coe_da_clk),
    .da_data (coe_da_data),
    .da_load (coe_da_load)
  );

endmodule
`default_nettype wire
